// File: rtl/program_loader.sv
// program_loader: loads a byte-streamed program image into instruction/immediate memory and holds the core in reset until loading is complete
// Ports: clk, rst (sync active-low); in_data/in_valid/in_ready byte stream; reload restarts loading;
//        pc -> instruction/imm combinational read; cpu_rst/loaded/load_err status; prog_len header record count
module program_loader #(
  parameter int BITNESS = 32,
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter logic [15:0] OOB_INSN = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               reload,
  input  logic [BITNESS-1:0] pc,
  output logic [15:0]        instruction,
  output logic [31:0]        imm,
  output logic               cpu_rst,
  output logic               loaded,
  output logic               load_err,
  output logic [15:0]        prog_len
);
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, RUN, ERR} state_t;
  state_t state, state_nx;
  logic [47:0] mem [DEPTH];
  logic [39:0] asm_q;
  logic [7:0] hdr_lo;
  logic [AW-1:0] rec_idx;
  logic [2:0] byte_idx;
  logic [15:0] hdr_n;
  logic acc, last, in_range;
  logic [47:0] rd;
  assign in_ready = state inside {HDR_LO, HDR_HI, DATA};
  assign load_err = state == ERR;
  assign acc = in_valid && in_ready;
  assign hdr_n = {in_data, hdr_lo};
  assign last = byte_idx == 3'd5 && {{(16-AW){1'b0}}, rec_idx} == prog_len - 16'd1;
  always_comb begin
    state_nx = state;
    if (reload)
      state_nx = HDR_LO;
    else if (acc)
      case (state)
        HDR_LO: state_nx = HDR_HI;
        HDR_HI: state_nx = hdr_n == 16'd0 ? RUN : (32'(hdr_n) > DEPTH ? ERR : DATA);
        DATA:   state_nx = last ? RUN : DATA;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HDR_LO;
      cpu_rst <= 1'b1;
      loaded <= 1'b0;
      prog_len <= 16'd0;
      rec_idx <= '0;
      byte_idx <= 3'd0;
      hdr_lo <= 8'd0;
    end else begin
      state <= state_nx;
      cpu_rst <= state_nx != RUN;
      loaded <= state_nx == RUN;
      if (reload) begin
        prog_len <= 16'd0;
        rec_idx <= '0;
        byte_idx <= 3'd0;
      end else if (acc) begin
        if (state == HDR_LO) hdr_lo <= in_data;
        if (state == HDR_HI) prog_len <= hdr_n;
        if (state == DATA) begin
          byte_idx <= byte_idx == 3'd5 ? 3'd0 : byte_idx + 3'd1;
          if (byte_idx == 3'd5) rec_idx <= rec_idx + 1'b1;
        end
      end
    end
  end
  // memory and assembly register are deliberately never reset; prog_len gates visibility
  always_ff @(posedge clk) begin
    if (rst && !reload && acc && state == DATA) begin
      asm_q <= {in_data, asm_q[39:8]};
      if (byte_idx == 3'd5) mem[rec_idx] <= {in_data, asm_q};
    end
  end
  // full-width compare so any pc bit above AW lands out of range; only RUN exposes the program
  assign in_range = loaded && pc < BITNESS'(prog_len);
  assign rd = mem[pc[AW-1:0]];
  assign instruction = in_range ? rd[15:0] : OOB_INSN;
  assign imm = in_range ? rd[47:16] : 32'd0;
endmodule
